main_memory: RTL



---
 rtl/main_memory_if.sv | 23 ++
 rtl/main_memory.sv | 112 +++++++++++
 2 files changed

// File: rtl/main_memory_if.sv
// Request/acknowledge bus between the cache arbiter (master) and main_memory (slave).
// mem_err exists only when MAIN_MEMORY_ALIGN_CHECK_EN is defined.
interface main_memory_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_ack;
  logic [31:0] mem_read_data;
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
  logic        mem_err;

  modport master (output mem_read, mem_write, mem_addr, mem_write_data,
                  input  mem_ack, mem_read_data, mem_err);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_write_data,
                  output mem_ack, mem_read_data, mem_err);
`else
  modport master (output mem_read, mem_write, mem_addr, mem_write_data,
                  input  mem_ack, mem_read_data);
  modport slave  (input  mem_read, mem_write, mem_addr, mem_write_data,
                  output mem_ack, mem_read_data);
`endif
endinterface

// File: rtl/main_memory.sv
// Word-addressed main memory with a fixed emulated access latency (IDLE/WAIT/ACK FSM).
// Optional MAIN_MEMORY_ALIGN_CHECK_EN flags misaligned/out-of-range addresses on mem_err.
module main_memory #(
  parameter int    ADDR_WIDTH = 12,
  parameter int    LATENCY    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic         clk,
  input  logic         reset,
  main_memory_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    wr_q;
  logic                    bad_q;
  logic [31:0]             rdata_q;
  logic [31:0]             mem_q [2**ADDR_WIDTH];

  logic                    req, accept, commit, addr_bad;
  logic [ADDR_WIDTH-1:0]   c_idx;
  logic [31:0]             c_wdata;
  logic                    c_wr, c_bad;

  assign req = bus.mem_read | bus.mem_write;

`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
  assign addr_bad = (|bus.mem_addr[1:0]) | (|bus.mem_addr[31:ADDR_WIDTH+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_WIDTH+2], bus.mem_addr[1:0]};
  assign addr_bad = 1'b0;
`endif

  // With LATENCY==1 the access happens on the accept edge, so use the live bus.
  assign c_idx   = (state_q == IDLE) ? bus.mem_addr[ADDR_WIDTH+1:2] : idx_q;
  assign c_wdata = (state_q == IDLE) ? bus.mem_write_data : wdata_q;
  assign c_wr    = (state_q == IDLE) ? bus.mem_write : wr_q;
  assign c_bad   = (state_q == IDLE) ? addr_bad : bad_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && !c_wr) rdata_q <= c_bad ? 32'hDEAD_BEEF : mem_q[c_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_ack       = (state_q == ACK);
    bus.mem_read_data = rdata_q;
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
    bus.mem_err       = (state_q == ACK) & bad_q;
`endif
  end

  // Transaction attributes are frozen at acceptance; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= bus.mem_addr[ADDR_WIDTH+1:2];
      wdata_q <= bus.mem_write_data;
      wr_q    <= bus.mem_write;
      bad_q   <= addr_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_wr && !c_bad && !reset) mem_q[c_idx] <= c_wdata;
  end

endmodule
